wb_sdram_bridge: RTL and testbench
==================================

# wb_sdram_bridge

Wishbone-classic slave that sits directly upstream of the SDRAM controller and converts 32-bit CPU/bus transactions into 16-bit native requests on the controller's command port. Each word access is split into a low and high half-word beat. Byte selects become DQM. Read beats are reassembled into one 32-bit response, with a timeout that turns a stalled controller into a bus error.

## Interface
- ADDR_BITS, 23, byte-address width of the SDRAM window (8 MB; x16 part, 4 banks × 4096 rows × 256 cols).
- RD_TIMEOUT, 255, max cycles from the first read request to the second read beat before ERR is raised.
- clk  in  1  system clock (50 MHz domain, same as controller command side).
- rst  in  1  reset. Asynchronous, active-low: assertion clears all state immediately, deassertion is sampled on clk.
- CYC, STB, WE  in  1 each  Wishbone cycle, strobe, write enable.
- ADR  in  32  byte address. Only [ADDR_BITS-1:0] is used; upstream decode selects this slave.
- DAT_O  in  32  write data from master.
- SEL  in  4  byte selects.
- CTI_O  in  3  cycle type. Ignored; every access is handled as classic.
- DAT_I  out  32  read data to master. Valid only while ACK=1.
- ACK, ERR, RTY  out  1 each  termination. RTY is constant 0.
- req_valid  out  1  native request valid.
- req_ready  in  1  controller accepts the request when valid&&ready at a clk edge.
- req_we  out  1  1 = write beat.
- req_addr  out  ADDR_BITS-1  half-word address: ADR[ADDR_BITS-1:1] with bit0 = beat index.
- req_wdata  out  16  write half-word.
- req_dqm  out  2  byte mask, 1 = masked.
- rd_valid  in  1  controller returns one read half-word, in request order.
- rd_data  in  16  returned half-word.

## Operation
- States:
  - IDLE
  - WR_LO, WR_HI
  - RD_LO, RD_HI, RD_WAIT
  - DRAIN
  - RESP
  - ERR_RESP
- IDLE, CYC&&STB, ADR[1:0]≠0: go to ERR_RESP. No downstream request is issued.
- IDLE, write (WE=1):
  - Latch ADR, DAT_O and SEL.
  - SEL[1:0]≠0: go to WR_LO.
  - Otherwise, SEL[3:2]≠0: go to WR_HI.
  - Otherwise (SEL=0): go to RESP.
- WR_LO:
  - Outputs: req_valid=1, req_we=1, addr bit0=0, wdata=DAT_O[15:0], dqm=~SEL[1:0].
  - On handshake: go to WR_HI if SEL[3:2]≠0, else RESP.
- WR_HI:
  - Outputs: addr bit0=1, wdata=DAT_O[31:16], dqm=~SEL[3:2].
  - On handshake: go to RESP.
- IDLE, read (WE=0): latch ADR, go to RD_LO.
- RD_LO: request low beat, dqm=00. Handshake moves to RD_HI.
- RD_HI: request high beat. Handshake moves to RD_WAIT.
- Read data capture:
  - rd_valid is accepted in RD_LO, RD_HI and RD_WAIT.
  - The first beat returned fills DAT_I[15:0], the second fills DAT_I[31:16].
  - A 1-bit beat counter tracks them. The second beat moves the FSM to RESP.
- Timeout:
  - A timeout counter starts when the FSM enters RD_LO and saturates.
  - If it reaches RD_TIMEOUT before the second beat, go to ERR_RESP.
- RESP: ACK=1 for exactly one cycle, then IDLE. ERR_RESP does the same with ERR.
- CYC drop mid-transaction:
  - An unissued beat is not issued.
  - A presented request (req_valid=1) is held until its handshake. req_valid never drops without a handshake.
  - If any read beats are still outstanding, go to DRAIN and discard the returned data.
  - Then go to IDLE with no ACK or ERR.
- DRAIN:
  - Drain waits until rd_valid has arrived once for every read request that was handshaked.
  - It is bounded by RD_TIMEOUT; on expiry go to IDLE.
- req_* outputs and DAT_I are registered. They are stable while req_valid=1 and not ready.
- rd_valid while in IDLE, WR_* or RESP is ignored.

## Timing
- Reset values: ACK=ERR=RTY=0, DAT_I=0, req_valid=0, req_we=0, req_addr=0, req_wdata=0, req_dqm=2'b11. FSM in IDLE, counters 0.
- Write, full word, req_ready=1:
  - STB sampled at edge 0.
  - req_valid on cycles 1–2 (lo, hi).
  - ACK on cycle 3.
- Write with only one half selected: ACK on cycle 2. SEL=0: ACK on cycle 1.
- Read: requests on cycles 1 and 2 when ready. ACK is the cycle after the second rd_valid.
- Stalls: each cycle of req_ready=0 adds one cycle.
- After RESP/ERR_RESP the bridge is in IDLE for one cycle. A new STB is sampled no earlier than 2 cycles after ACK.
- rd_valid in the same cycle as the RD_HI handshake: both are taken. If that was the second beat, go straight to RESP.

## Test plan
- Write, ADR=0x0000_0100, DAT_O=0xDEAD_BEEF, SEL=4'hF, ready=1 -> two requests (addr 0x80, data 0xBEEF, dqm 00; addr 0x81, data 0xDEAD, dqm 00), then ACK 3 cycles after STB.
- Write, SEL=4'b0100, DAT_O=0x1234_5678 -> one request at addr bit0=1, data 0x1234, dqm 2'b10, then ACK. SEL=0 -> no request, ACK at cycle 1.
- Read, ADR=0x100, controller returns 0xBEEF then 0xDEAD with 3-cycle latency and ready low for 2 cycles on the high beat -> DAT_I=0xDEADBEEF with ACK.
- ADR=0x102 -> ERR one cycle, no req_valid. Read with rd_valid never returned -> ERR exactly RD_TIMEOUT cycles after entering RD_LO.
- CYC dropped after the low read beat handshakes -> high beat not issued; returning beat is discarded; no ACK; next read returns correct data.
- rst asserted while in WR_HI with ready=0 -> all outputs at reset values immediately (asynchronous); after release a clean write completes normally.

Source files
------------

// File: rtl/wb_sdram_bridge_if.sv
// Wishbone-classic bus bundle between the CPU-side master and the SDRAM bridge.
interface wb_sdram_bridge_if;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic [31:0] ADR;
    logic [31:0] DAT_O;
    logic [3:0]  SEL;
    logic [2:0]  CTI_O;
    logic [31:0] DAT_I;
    logic        ACK;
    logic        ERR;
    logic        RTY;

    modport master (output CYC, STB, WE, ADR, DAT_O, SEL, CTI_O,
                    input  DAT_I, ACK, ERR, RTY);
    modport slave  (input  CYC, STB, WE, ADR, DAT_O, SEL, CTI_O,
                    output DAT_I, ACK, ERR, RTY);
endinterface

// File: rtl/wb_sdram_bridge.sv
// Wishbone-classic 32-bit slave -> 16-bit native SDRAM controller requests.
// Each word is split into low/high half-word beats; read beats are reassembled
// and a stalled read turns into a bus error after RD_TIMEOUT cycles.
module wb_sdram_bridge #(
    parameter int ADDR_BITS  = 23,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_sdram_bridge_if.slave     wb,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic                 req_we,
    output logic [ADDR_BITS-2:0] req_addr,
    output logic [15:0]          req_wdata,
    output logic [1:0]           req_dqm,
    input  logic                 rd_valid,
    input  logic [15:0]          rd_data
);
    localparam int TW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, DRAIN, RESP, ERR_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:2]   adr_q, adr_d;
    logic [31:0]            wdat_q, wdat_d;
    logic [3:0]             sel_q, sel_d;
    logic [1:0]             iss_q, iss_d;      // read beats handshaked
    logic [1:0]             ret_q, ret_d;      // read beats returned; bit0 is the beat index
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [31:0]            rdat_q, rdat_d;

    logic                   vld_d, we_d, ack_q, ack_d, err_q, err_d, hi_d;
    logic [ADDR_BITS-2:0]   addr_d;
    logic [15:0]            wdata_d;
    logic [1:0]             dqm_d;

    logic hs, rd_take, second, tmo_exp;

    // CTI and the address bits above the window are decoded upstream
    logic unused_wb;
    assign unused_wb = ^{wb.CTI_O, wb.ADR[31:ADDR_BITS]};

    assign wb.DAT_I = rdat_q;
    assign wb.ACK   = ack_q;
    assign wb.ERR   = err_q;
    assign wb.RTY   = 1'b0;

    // Next-state, read reassembly, counters and registered-output values
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        iss_d   = iss_q;
        ret_d   = ret_q;
        tmo_d   = tmo_q;
        rdat_d  = rdat_q;

        hs      = req_valid && req_ready;
        rd_take = rd_valid && (state_q inside {RD_LO, RD_HI, RD_WAIT, DRAIN});
        second  = rd_take && ret_q[0] && (state_q != DRAIN);
        tmo_exp = tmo_q >= TW'(RD_TIMEOUT - 1);

        if (hs && (state_q inside {RD_LO, RD_HI}))
            iss_d = iss_q + 2'd1;
        if (rd_take) begin
            ret_d = ret_q + 2'd1;
            // beats caught while draining belong to an abandoned access
            if (state_q != DRAIN) begin
                if (ret_q[0]) rdat_d[31:16] = rd_data;
                else          rdat_d[15:0]  = rd_data;
            end
        end
        if ((state_q inside {RD_LO, RD_HI, RD_WAIT, DRAIN}) && tmo_q != TW'(RD_TIMEOUT))
            tmo_d = tmo_q + TW'(1);

        case (state_q)
            IDLE: begin
                iss_d = '0;
                ret_d = '0;
                tmo_d = '0;
                if (wb.CYC && wb.STB) begin
                    if (wb.ADR[1:0] != 2'b00) begin
                        state_d = ERR_RESP;
                    end else begin
                        adr_d  = wb.ADR[ADDR_BITS-1:2];
                        wdat_d = wb.DAT_O;
                        sel_d  = wb.SEL;
                        if (!wb.WE)                 state_d = RD_LO;
                        else if (wb.SEL[1:0] != 0)  state_d = WR_LO;
                        else if (wb.SEL[3:2] != 0)  state_d = WR_HI;
                        else                        state_d = RESP;
                    end
                end
            end
            WR_LO: if (hs) begin
                if (!wb.CYC)                state_d = IDLE;
                else if (sel_q[3:2] != 0)   state_d = WR_HI;
                else                        state_d = RESP;
            end
            WR_HI: if (hs) state_d = wb.CYC ? RESP : IDLE;
            RD_LO, RD_HI, RD_WAIT: begin
                if (!wb.CYC) begin
                    // a presented beat must complete its handshake before we leave
                    if (!req_valid || hs)
                        state_d = (iss_d != ret_d) ? DRAIN : IDLE;
                end else if (second)  state_d = RESP;
                else if (tmo_exp)     state_d = ERR_RESP;
                else if (hs)          state_d = (state_q == RD_LO) ? RD_HI : RD_WAIT;
            end
            DRAIN:    if (ret_d == iss_q || tmo_exp) state_d = IDLE;
            RESP:     state_d = IDLE;
            ERR_RESP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        vld_d   = state_d inside {WR_LO, WR_HI, RD_LO, RD_HI};
        we_d    = state_d inside {WR_LO, WR_HI};
        hi_d    = state_d inside {WR_HI, RD_HI};
        addr_d  = {adr_d, hi_d};
        ack_d   = state_d == RESP;
        err_d   = state_d == ERR_RESP;
        wdata_d = '0;
        dqm_d   = 2'b11;
        case (state_d)
            WR_LO:        begin wdata_d = wdat_d[15:0];  dqm_d = ~sel_d[1:0]; end
            WR_HI:        begin wdata_d = wdat_d[31:16]; dqm_d = ~sel_d[3:2]; end
            RD_LO, RD_HI: dqm_d = 2'b00;
            default:      ;
        endcase
    end

    // FSM state, latched bus request and read bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            tmo_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            tmo_q   <= tmo_d;
            rdat_q  <= rdat_d;
        end
    end

    // Registered outputs, so they stay put while the controller stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_dqm   <= 2'b11;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_valid <= vld_d;
            req_we    <= we_d;
            req_addr  <= addr_d;
            req_wdata <= wdata_d;
            req_dqm   <= dqm_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_sdram_bridge.sv
// Scoreboard bench for wb_sdram_bridge: expected native requests and bus
// responses are queued as stimulus is issued and checked as the DUT emits them.
module tb_wb_sdram_bridge;
    localparam int AB  = 23;
    localparam int TMO = 255;
    localparam int LAT = 3;   // beat handshaked at edge h is returned, sampled at edge h+LAT

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    wb_sdram_bridge_if wb();
    logic          req_valid, req_ready, req_we, rd_valid;
    logic [AB-2:0] req_addr;
    logic [15:0]   req_wdata, rd_data;
    logic [1:0]    req_dqm;

    wb_sdram_bridge #(.ADDR_BITS(AB), .RD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wb(wb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dqm(req_dqm),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    typedef struct packed {
        logic          we;
        logic [AB-2:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    dqm;
    } req_t;
    typedef struct {
        logic        err;
        logic [31:0] dat;
        logic        chk_dat;
    } rsp_t;

    req_t        exp_req[$];
    rsp_t        exp_rsp[$];
    logic [15:0] ret_q[$];
    int          pend[$];

    int   n_run = 0, n_fail = 0;
    int   cyc = 0;
    int   stall_lo = 0, stall_hi = 0;
    logic ready_dflt = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [AB-2:0] a, input logic [15:0] d, input logic [1:0] m);
        req_t r;
        r.we = we; r.addr = a; r.wdata = d; r.dqm = m;
        exp_req.push_back(r);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: check every handshake and every termination
    always @(negedge clk) begin : mon
        req_t e;
        rsp_t r;
        if (rst) begin
            if (req_valid && req_ready) begin
                if (!req_we) pend.push_back(cyc + LAT);
                if (exp_req.size() == 0) chk("req_extra", 1, 0);
                else begin
                    e = exp_req.pop_front();
                    chk("req", {req_we, req_addr, req_wdata, req_dqm}, e);
                end
            end
            if (wb.ACK || wb.ERR) begin
                chk("rty", wb.RTY, 0);
                if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
                else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_err", wb.ERR, r.err);
                    chk("rsp_ack", wb.ACK, !r.err);
                    if (r.chk_dat) chk("rsp_dat", wb.DAT_I, r.dat);
                end
            end
        end
    end

    // Controller model: ready with per-beat stalls, reads returned in order
    initial begin
        req_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (req_valid && !req_addr[0] && stall_lo > 0) begin req_ready = 1'b0; stall_lo--; end
            else if (req_valid && req_addr[0] && stall_hi > 0) begin req_ready = 1'b0; stall_hi--; end
            else req_ready = ready_dflt;
            rd_valid = 1'b0;
            if (pend.size() > 0 && pend[0] <= cyc) begin
                void'(pend.pop_front());
                if (ret_q.size() > 0) begin
                    rd_valid = 1'b1;
                    rd_data  = ret_q.pop_front();
                end
            end
        end
    end

    task automatic wb_xfer(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_dat, input logic chk_dat);
        rsp_t r;
        int   lat;
        r.err = exp_err; r.dat = exp_dat; r.chk_dat = chk_dat;
        exp_rsp.push_back(r);
        @(posedge clk); #1;
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = we; wb.ADR = adr; wb.DAT_O = dat; wb.SEL = sel;
        @(posedge clk); #1;          // edge 0 samples STB; we now see cycle 1
        lat = 1;
        while (!(wb.ACK || wb.ERR) && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        wb.CYC = 1'b0; wb.STB = 1'b0; wb.WE = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req"}, {req_valid, req_we, req_addr, req_wdata, req_dqm}, {2'b00, 22'h0, 16'h0, 2'b11});
        chk({tag, "_term"}, {wb.ACK, wb.ERR, wb.RTY}, 3'b000);
        chk({tag, "_dat"}, wb.DAT_I, 32'h0);
    endtask

    initial begin
        wb.CYC = 0; wb.STB = 0; wb.WE = 0; wb.ADR = '0; wb.DAT_O = '0; wb.SEL = '0; wb.CTI_O = 3'b010;
        rst = 1'b1;
        #3 rst = 1'b0;
        #2 chk_reset_outs("rst_in");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_reset_outs("rst_out");

        // full-word write: lo then hi beat, ACK in cycle 3
        push_req(1, 22'h80, 16'hBEEF, 2'b00);
        push_req(1, 22'h81, 16'hDEAD, 2'b00);
        wb_xfer("wr_full", 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 0, 0, 0);
        // single high byte: only the hi beat, dqm masks byte 3
        push_req(1, 22'h81, 16'h1234, 2'b10);
        wb_xfer("wr_hi", 1, 32'h0000_0100, 32'h1234_5678, 4'b0100, 2, 0, 0, 0);
        // single low-half byte 1
        push_req(1, 22'h82, 16'h5678, 2'b01);
        wb_xfer("wr_lo", 1, 32'h0000_0104, 32'h1234_5678, 4'b0010, 2, 0, 0, 0);
        // no bytes selected: no request, ACK in cycle 1
        wb_xfer("wr_sel0", 1, 32'h0000_0108, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, 0);
        // misaligned: ERR in cycle 1, nothing downstream
        wb_xfer("rd_mis", 0, 32'h0000_0102, 0, 4'hF, 1, 1, 0, 0);
        wb_xfer("wr_mis", 1, 32'h0000_0101, 32'h1, 4'hF, 1, 1, 0, 0);

        // read, hi beat stalled 2 cycles: hs edges 1 and 4, beats at edges 4 and 7, ACK cycle 8
        stall_hi = 2;
        push_req(0, 22'h80, 16'h0, 2'b00);
        push_req(0, 22'h81, 16'h0, 2'b00);
        ret_q.push_back(16'hBEEF); ret_q.push_back(16'hDEAD);
        wb_xfer("rd_stall", 0, 32'h0000_0100, 0, 4'hF, 8, 0, 32'hDEAD_BEEF, 1);

        // read at top of window with junk above it: hs edges 1,2, last beat edge 5, ACK cycle 6
        push_req(0, 22'h3FFFFE, 16'h0, 2'b00);
        push_req(0, 22'h3FFFFF, 16'h0, 2'b00);
        ret_q.push_back(16'h0123); ret_q.push_back(16'h4567);
        wb_xfer("rd_top", 0, 32'hFF7F_FFFC, 0, 4'hF, 6, 0, 32'h4567_0123, 1);

        // controller never returns data: ERR TMO cycles after entering RD_LO
        push_req(0, 22'h100, 16'h0, 2'b00);
        push_req(0, 22'h101, 16'h0, 2'b00);
        wb_xfer("rd_tmo", 0, 32'h0000_0200, 0, 4'hF, TMO + 1, 1, 0, 0);
        chk("tmo_pend", pend.size(), 0);

        // CYC dropped while the lo beat is stalled: lo completes, hi never issued, beat drained
        stall_lo = 1;
        push_req(0, 22'h100, 16'h0, 2'b00);
        ret_q.push_back(16'h1111);
        @(posedge clk); #1;
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = 1'b0; wb.ADR = 32'h0000_0200; wb.SEL = 4'hF;
        @(posedge clk); #1;
        wb.CYC = 1'b0; wb.STB = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("drop_req_q", exp_req.size(), 0);
        chk("drop_ret_q", ret_q.size(), 0);
        chk("drop_term", {wb.ACK, wb.ERR}, 2'b00);
        push_req(0, 22'h100, 16'h0, 2'b00);
        push_req(0, 22'h101, 16'h0, 2'b00);
        ret_q.push_back(16'hCAFE); ret_q.push_back(16'hF00D);
        wb_xfer("rd_after_drop", 0, 32'h0000_0200, 0, 4'hF, 6, 0, 32'hF00D_CAFE, 1);

        // asynchronous reset while WR_HI is stalled
        stall_hi = 100;
        push_req(1, 22'h180, 16'h5555, 2'b00);
        @(posedge clk); #1;
        wb.CYC = 1'b1; wb.STB = 1'b1; wb.WE = 1'b1; wb.ADR = 32'h0000_0300; wb.DAT_O = 32'hAAAA_5555; wb.SEL = 4'hF;
        repeat (3) @(posedge clk);
        #1 chk("stall_hi_vld", {req_valid, req_addr[0], req_ready}, 3'b110);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_reset_outs("rst_async");
        stall_hi = 0;
        wb.CYC = 1'b0; wb.STB = 1'b0; wb.WE = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        push_req(1, 22'h180, 16'h5555, 2'b00);
        push_req(1, 22'h181, 16'hAAAA, 2'b00);
        wb_xfer("wr_post_rst", 1, 32'h0000_0300, 32'hAAAA_5555, 4'hF, 3, 0, 0, 0);

        repeat (4) @(posedge clk);
        chk("end_req_q", exp_req.size(), 0);
        chk("end_rsp_q", exp_rsp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
